baseline_trigger: RTL and testbench

- Sits directly downstream of the baseline-averaging IIR stage.
- Takes the raw ADC sample stream `x` and the averaged baseline from that stage, and subtracts the baseline with saturation.
- Runs a threshold/width discriminator FSM on the corrected stream.
- Outputs: a trigger pulse, the per-event peak amplitude and a free-running timestamp captured at event start. These feed the readout/self-trigger logic.

---
 rtl/baseline_trigger.sv | 168 ++++++++++++++++
 tb/tb_baseline_trigger.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/baseline_trigger.sv
// baseline_trigger: subtracts the averaged baseline from the raw ADC stream
// with saturation, then runs a threshold/width discriminator that emits a
// trigger pulse, the event peak and the event start timestamp.
module baseline_trigger #(
  parameter int MIN_WIDTH = 4,
  parameter int HOLDOFF   = 64,
  parameter int TS_W      = 48
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic signed [15:0] x,
  input  logic signed [15:0] baseline,
  input  logic               baseline_valid,
  input  logic signed [15:0] threshold,
  output logic signed [15:0] x_sub,
  output logic               trig,
  output logic signed [15:0] peak,
  output logic               peak_valid,
  output logic [TS_W-1:0]    event_ts,
  output logic               busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_ABOVE,
    ST_HOLDOFF
  } state_t;

  state_t             state;
  logic               reset_reg;
  logic               enable_reg;
  logic signed [15:0] x_reg;
  logic signed [15:0] baseline_reg;
  logic signed [16:0] diff;
  logic signed [15:0] diff_sat;
  logic [TS_W-1:0]    ts;
  logic [TS_W-1:0]    ts_acc;
  logic signed [15:0] peak_acc;
  logic [7:0]         width;
  logic [8:0]         width_inc;
  logic [15:0]        hold_cnt;
  logic               above;

  // Register reset and enable once so control timing lines up with the upstream stage.
  always_ff @(posedge clk) begin
    reset_reg  <= reset;
    enable_reg <= enable;
  end

  // Stage 1: capture the raw sample and the baseline together.
  always_ff @(posedge clk) begin
    if (reset_reg) begin
      x_reg        <= '0;
      baseline_reg <= '0;
    end else begin
      x_reg        <= x;
      baseline_reg <= baseline;
    end
  end

  assign diff = {x_reg[15], x_reg} - {baseline_reg[15], baseline_reg};

  // Clamp the 17-bit difference into the 16-bit signed range.
  always_comb begin
    diff_sat = diff[15:0];
    if (diff[16] != diff[15]) begin
      diff_sat = diff[16] ? 16'sh8000 : 16'sh7fff;
    end
  end

  // Stage 2: the corrected sample, running independent of the discriminator.
  always_ff @(posedge clk) begin
    if (reset_reg) begin
      x_sub <= '0;
    end else begin
      x_sub <= diff_sat;
    end
  end

  // Free-running timestamp; wraps silently.
  always_ff @(posedge clk) begin
    if (reset_reg) begin
      ts <= '0;
    end else begin
      ts <= ts + TS_W'(1);
    end
  end

  assign above     = (x_sub > threshold);
  assign width_inc = {1'b0, width} + 9'd1;

  // Discriminator FSM with registered trigger, peak and timestamp outputs.
  always_ff @(posedge clk) begin
    if (reset_reg) begin
      state      <= ST_IDLE;
      width      <= '0;
      hold_cnt   <= '0;
      peak_acc   <= '0;
      ts_acc     <= '0;
      trig       <= 1'b0;
      peak_valid <= 1'b0;
      peak       <= '0;
      event_ts   <= '0;
      busy       <= 1'b0;
    end else begin
      trig       <= 1'b0;
      peak_valid <= 1'b0;
      if (!enable_reg || !baseline_valid) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            state <= ST_ARMED;
            busy  <= 1'b0;
          end
          ST_ARMED: begin
            if (above) begin
              state    <= ST_ABOVE;
              busy     <= 1'b1;
              width    <= 8'd1;
              peak_acc <= x_sub;
              ts_acc   <= ts;
              trig     <= (MIN_WIDTH == 1);
            end
          end
          ST_ABOVE: begin
            if (above) begin
              if (width != 8'd255) begin
                width <= width + 8'd1;
              end
              if (x_sub > peak_acc) begin
                peak_acc <= x_sub;
              end
              if (width_inc == 9'(MIN_WIDTH)) begin
                trig <= 1'b1;
              end
            end else if (int'(width) >= MIN_WIDTH) begin
              peak       <= peak_acc;
              event_ts   <= ts_acc;
              peak_valid <= 1'b1;
              hold_cnt   <= '0;
              state      <= ST_HOLDOFF;
            end else begin
              state <= ST_ARMED;
              busy  <= 1'b0;
            end
          end
          ST_HOLDOFF: begin
            if (hold_cnt == 16'(HOLDOFF - 1)) begin
              state <= ST_ARMED;
              busy  <= 1'b0;
            end else begin
              hold_cnt <= hold_cnt + 16'd1;
            end
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_baseline_trigger.sv
// Directed testbench for baseline_trigger: latency, saturation, glitch
// rejection, accepted events, holdoff and enable/baseline gating.
module tb_baseline_trigger;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] x;
  logic [15:0] baseline;
  logic        baselineValid;
  logic [15:0] threshold;
  logic [15:0] xSub;
  logic        trig;
  logic [15:0] peak;
  logic        peakValid;
  logic [47:0] eventTs;
  logic        busy;

  int          checkCount  = 0;
  int          errorCount  = 0;
  int          cyc         = 0;
  int          c0          = 0;
  int          trigCount   = 0;
  int          pvCount     = 0;
  int          lastTrigCyc = -1;
  int          lastPvCyc   = -1;
  logic [15:0] lastPeak    = '0;
  logic [47:0] lastTs      = '0;
  int          firstCyc    = 0;
  int          fourthCyc   = 0;
  int          dropCyc     = 0;
  int          evCyc       = 0;
  int          expTs       = 0;

  baseline_trigger #(
    .MIN_WIDTH(4),
    .HOLDOFF  (64),
    .TS_W     (48)
  ) dut (
    .clk           (clock),
    .reset         (reset),
    .enable        (enable),
    .x             (x),
    .baseline      (baseline),
    .baseline_valid(baselineValid),
    .threshold     (threshold),
    .x_sub         (xSub),
    .trig          (trig),
    .peak          (peak),
    .peak_valid    (peakValid),
    .event_ts      (eventTs),
    .busy          (busy)
  );

  // Free-running 10-time-unit clock.
  always #5 clock = ~clock;

  // Compare one observed value against its expected value and count it.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock, sample just after the edge and log strobes.
  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    if (trig) begin
      trigCount++;
      lastTrigCyc = cyc;
    end
    if (peakValid) begin
      pvCount++;
      lastPvCyc = cyc;
      lastPeak  = peak;
      lastTs    = eventTs;
    end
  endtask

  task automatic applyStimulus(input logic [15:0] xs);
    x = xs;
    tick();
  endtask

  task automatic idleUntil(input int target);
    while (cyc < target) applyStimulus(16'd0);
  endtask

  task automatic clearCounts();
    trigCount   = 0;
    pvCount     = 0;
    lastTrigCyc = -1;
    lastPvCyc   = -1;
  endtask

  // Qualifying pulse 60,80,pk,90,70 then 40 (at threshold 50, 40 ends it).
  task automatic sendPulse(input logic [15:0] pk);
    applyStimulus(16'd60);
    firstCyc = cyc;
    applyStimulus(16'd80);
    applyStimulus(pk);
    applyStimulus(16'd90);
    fourthCyc = cyc;
    applyStimulus(16'd70);
    applyStimulus(16'd40);
    dropCyc = cyc;
  endtask

  initial begin
    reset         = 1'b1;
    enable        = 1'b0;
    baselineValid = 1'b0;
    x             = '0;
    baseline      = '0;
    threshold     = 16'd50;
    repeat (3) tick();
    checkOutput("rst_xsub", 64'(xSub), 64'd0);
    checkOutput("rst_trig", 64'(trig), 64'd0);
    checkOutput("rst_pv", 64'(peakValid), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_peak", 64'(peak), 64'd0);
    checkOutput("rst_ts", 64'(eventTs), 64'd0);

    // Release reset with x equal to baseline.
    reset    = 1'b0;
    x        = 16'd100;
    baseline = 16'd100;
    tick();
    c0 = cyc;
    clearCounts();
    repeat (5) tick();
    checkOutput("flat_xsub", 64'(xSub), 64'd0);
    checkOutput("flat_trig", 64'(trigCount), 64'd0);
    checkOutput("flat_busy", 64'(busy), 64'd0);

    // Two-cycle latency and saturation.
    x        = 16'h7fff;
    baseline = 16'hff9c;
    tick();
    checkOutput("lat_1cyc", 64'(xSub), 64'd0);
    tick();
    checkOutput("sat_pos", 64'(xSub), 64'h7fff);
    x        = 16'h8000;
    baseline = 16'd100;
    tick();
    tick();
    checkOutput("sat_neg", 64'(xSub), 64'h8000);
    x        = 16'd1000;
    baseline = 16'hff38;
    tick();
    tick();
    checkOutput("sub_plain", 64'(xSub), 64'd1200);

    // Arm the discriminator.
    baseline      = '0;
    x             = '0;
    enable        = 1'b1;
    baselineValid = 1'b1;
    repeat (4) tick();

    // Glitch of three samples is rejected.
    clearCounts();
    repeat (3) applyStimulus(16'd60);
    repeat (6) applyStimulus(16'd0);
    checkOutput("glitch_trig", 64'(trigCount), 64'd0);
    checkOutput("glitch_pv", 64'(pvCount), 64'd0);
    checkOutput("glitch_busy", 64'(busy), 64'd0);

    // Accepted event.
    clearCounts();
    sendPulse(16'd120);
    expTs = firstCyc + 1 - c0;
    evCyc = dropCyc + 2;
    idleUntil(evCyc);
    checkOutput("ev1_trig_cnt", 64'(trigCount), 64'd1);
    checkOutput("ev1_trig_cyc", 64'(lastTrigCyc), 64'(fourthCyc + 2));
    checkOutput("ev1_pv_cnt", 64'(pvCount), 64'd1);
    checkOutput("ev1_pv_cyc", 64'(lastPvCyc), 64'(evCyc));
    checkOutput("ev1_peak", 64'(lastPeak), 64'd120);
    checkOutput("ev1_ts", 64'(lastTs), 64'(expTs));
    idleUntil(evCyc + 63);
    checkOutput("ev1_busy_hold", 64'(busy), 64'd1);
    applyStimulus(16'd0);
    checkOutput("ev1_busy_end", 64'(busy), 64'd0);
    checkOutput("ev1_peak_held", 64'(peak), 64'd120);

    // Holdoff: pulse 10 cycles after peak_valid ignored, 70 cycles after accepted.
    clearCounts();
    sendPulse(16'd120);
    evCyc = dropCyc + 2;
    idleUntil(evCyc + 9);
    sendPulse(16'd250);
    idleUntil(evCyc + 40);
    checkOutput("hold_trig_cnt", 64'(trigCount), 64'd1);
    checkOutput("hold_pv_cnt", 64'(pvCount), 64'd1);
    idleUntil(evCyc + 69);
    sendPulse(16'd200);
    expTs = firstCyc + 1 - c0;
    idleUntil(dropCyc + 3);
    checkOutput("rearm_trig_cnt", 64'(trigCount), 64'd2);
    checkOutput("rearm_pv_cnt", 64'(pvCount), 64'd2);
    checkOutput("rearm_peak", 64'(lastPeak), 64'd200);
    checkOutput("rearm_ts", 64'(lastTs), 64'(expTs));

    // Baseline not valid: nothing triggers.
    idleUntil(dropCyc + 2 + 66);
    baselineValid = 1'b0;
    repeat (3) tick();
    clearCounts();
    sendPulse(16'd300);
    repeat (10) applyStimulus(16'd0);
    checkOutput("gate_trig", 64'(trigCount), 64'd0);
    checkOutput("gate_pv", 64'(pvCount), 64'd0);
    checkOutput("gate_busy", 64'(busy), 64'd0);

    // Enable dropped after trig: event aborted without peak_valid.
    baselineValid = 1'b1;
    repeat (3) tick();
    clearCounts();
    applyStimulus(16'd60);
    applyStimulus(16'd80);
    applyStimulus(16'd120);
    applyStimulus(16'd90);
    fourthCyc = cyc;
    applyStimulus(16'd70);
    applyStimulus(16'd70);
    enable = 1'b0;
    applyStimulus(16'd70);
    repeat (10) applyStimulus(16'd0);
    checkOutput("abort_trig_cnt", 64'(trigCount), 64'd1);
    checkOutput("abort_trig_cyc", 64'(lastTrigCyc), 64'(fourthCyc + 2));
    checkOutput("abort_pv", 64'(pvCount), 64'd0);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_peak_held", 64'(peak), 64'd200);
    x = 16'd500;
    tick();
    tick();
    checkOutput("xsub_disabled", 64'(xSub), 64'd500);
    x = '0;

    // Re-enable: back to ARMED and accepting.
    enable = 1'b1;
    repeat (4) applyStimulus(16'd0);
    clearCounts();
    sendPulse(16'd150);
    idleUntil(dropCyc + 3);
    checkOutput("reen_trig_cnt", 64'(trigCount), 64'd1);
    checkOutput("reen_pv_cnt", 64'(pvCount), 64'd1);
    checkOutput("reen_peak", 64'(lastPeak), 64'd150);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
